stream_accumulator: RTL and testbench

STREAM_ACCUMULATOR -- requirements
Module: stream_accumulator

---
 rtl/stream_accumulator.sv | 70 +++++++
 tb/tb_stream_accumulator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_accumulator.sv
// stream_accumulator: one-deep ADD/SUB/ACC/CLR pipeline with a framed, optionally saturating accumulator
module stream_accumulator #(
  parameter int WIDTH = 8,
  parameter int ACC_WIDTH = 16,
  parameter int SAT_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [1:0]           in_op,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  output logic [7:0]           out_count
);
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ACC = 2'b10, OP_CLR = 2'b11;
  localparam logic [0:0] IDLE = 1'b0, ACCUM = 1'b1;
  logic [0:0]           state;
  logic [ACC_WIDTH-1:0] acc, acc_base, acc_nxt, add_res, sub_res;
  logic [ACC_WIDTH:0]   sum;
  logic [7:0]           cnt, cnt_nxt;
  logic                 sticky, ovf_beat, fire, produce, clear;
  assign in_ready = !rst && (!out_valid || out_ready);
  assign fire = in_valid && in_ready;
  assign produce = fire && (in_op != OP_CLR) && (in_op != OP_ACC || in_last);
  assign clear = fire && (in_op == OP_CLR || (in_op == OP_ACC && in_last));
  always_comb begin
    acc_base = (state == ACCUM) ? acc : '0;
    sum = {1'b0, acc_base} + (ACC_WIDTH+1)'(in_a) + (ACC_WIDTH+1)'(in_b);
    ovf_beat = sum[ACC_WIDTH];
    acc_nxt = (ovf_beat && SAT_EN != 0) ? '1 : sum[ACC_WIDTH-1:0];
    cnt_nxt = (state == IDLE) ? 8'd1 : (cnt == 8'hff) ? cnt : cnt + 8'd1;
    add_res = ACC_WIDTH'(in_a) + ACC_WIDTH'(in_b);
    sub_res = ACC_WIDTH'(in_a) - ACC_WIDTH'(in_b);
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      sticky <= 1'b0;
    end else if (fire && in_op == OP_ACC) begin
      state <= ACCUM;
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      sticky <= sticky | ovf_beat;
    end
  end
  // a new result may load in the same edge the previous one is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ovf <= 1'b0;
      out_count <= '0;
    end else if (produce) begin
      out_valid <= 1'b1;
      out_data <= (in_op == OP_ADD) ? add_res : (in_op == OP_SUB) ? sub_res : acc_nxt;
      out_ovf <= (in_op == OP_SUB) ? (in_a < in_b) : (in_op == OP_ACC) ? (sticky | ovf_beat) : 1'b0;
      out_count <= (in_op == OP_ACC) ? cnt_nxt : 8'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_accumulator.sv
// tb_stream_accumulator: directed and randomized checks of saturating and wrapping instances side by side
module tb_stream_accumulator;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, CLR = 2'b11;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
  logic [1:0] in_op = 0;
  logic [7:0] in_a = 0, in_b = 0;
  logic sr, sv, so, wr, wv, wo;
  logic [9:0] sd, wd;
  logic [7:0] sc, wc;
  int pass_n = 0, total_n = 0;

  stream_accumulator #(.WIDTH(8), .ACC_WIDTH(10), .SAT_EN(1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sr), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .in_last(in_last), .out_valid(sv), .out_ready(out_ready),
    .out_data(sd), .out_ovf(so), .out_count(sc));
  stream_accumulator #(.WIDTH(8), .ACC_WIDTH(10), .SAT_EN(0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(wr), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .in_last(in_last), .out_valid(wv), .out_ready(out_ready),
    .out_data(wd), .out_ovf(wo), .out_count(wc));

  always #5 clk = ~clk;

  task set(input logic v, input logic [1:0] op, input int a, input int b, input logic last, input logic ordy);
    in_valid = v; in_op = op; in_a = a[7:0]; in_b = b[7:0]; in_last = last; out_ready = ordy;
  endtask
  task tick;
    @(posedge clk); #1;
  endtask
  task idle;
    set(0, ADD, 0, 0, 0, 1); tick;
  endtask

  task test_reset;
    rst = 1; set(1, ADD, 1, 1, 0, 1); #1;
    total_n++;
    if ({sr, wr} !== 2'b00) $display("FAIL reset_in_ready got %b%b want 00", sr, wr); else pass_n++;
    tick; tick;
    total_n++;
    if ({sv, sd, so, sc, wv, wd, wo, wc} !== '0)
      $display("FAIL reset_outputs got v=%b d=%0d o=%b c=%0d / v=%b d=%0d o=%b c=%0d want zeros", sv, sd, so, sc, wv, wd, wo, wc);
    else pass_n++;
    rst = 0; set(0, ADD, 0, 0, 0, 0); #1;
    total_n++;
    if ({sr, wr} !== 2'b11) $display("FAIL post_reset_ready got %b%b want 11", sr, wr); else pass_n++;
    tick;
  endtask

  task test_add;
    set(1, ADD, 200, 100, 0, 1); tick;
    total_n++;
    if ({sv, sd, so, sc} !== {1'b1, 10'd300, 1'b0, 8'd1}) $display("FAIL add got v=%b d=%0d o=%b c=%0d want 1 300 0 1", sv, sd, so, sc); else pass_n++;
    idle;
  endtask

  task test_sub;
    set(1, SUB, 5, 7, 0, 1); tick;
    total_n++;
    if ({sv, sd, so, sc} !== {1'b1, 10'd1022, 1'b1, 8'd1}) $display("FAIL sub_borrow got v=%b d=%0d o=%b c=%0d want 1 1022 1 1", sv, sd, so, sc); else pass_n++;
    set(1, SUB, 7, 5, 0, 1); tick;
    total_n++;
    if ({sv, sd, so, sc} !== {1'b1, 10'd2, 1'b0, 8'd1}) $display("FAIL sub got v=%b d=%0d o=%b c=%0d want 1 2 0 1", sv, sd, so, sc); else pass_n++;
    idle;
  endtask

  task test_acc;
    set(1, ACC, 10, 20, 0, 1); tick;
    total_n++;
    if (sv !== 1'b0) $display("FAIL acc_beat1_valid got %b want 0", sv); else pass_n++;
    set(1, ACC, 30, 40, 0, 1); tick;
    total_n++;
    if (sv !== 1'b0) $display("FAIL acc_beat2_valid got %b want 0", sv); else pass_n++;
    set(1, ACC, 1, 2, 1, 1); tick;
    total_n++;
    if ({sv, sd, so, sc} !== {1'b1, 10'd103, 1'b0, 8'd3}) $display("FAIL acc_frame got v=%b d=%0d o=%b c=%0d want 1 103 0 3", sv, sd, so, sc); else pass_n++;
    idle;
    total_n++;
    if (sv !== 1'b0) $display("FAIL acc_drain got %b want 0", sv); else pass_n++;
  endtask

  task test_saturate;
    set(1, ACC, 255, 255, 0, 1); tick; tick;
    set(1, ACC, 255, 255, 1, 1); tick;
    total_n++;
    if ({sv, sd, so, sc} !== {1'b1, 10'd1023, 1'b1, 8'd3}) $display("FAIL sat_frame got v=%b d=%0d o=%b c=%0d want 1 1023 1 3", sv, sd, so, sc); else pass_n++;
    total_n++;
    if ({wv, wd, wo, wc} !== {1'b1, 10'd506, 1'b1, 8'd3}) $display("FAIL wrap_frame got v=%b d=%0d o=%b c=%0d want 1 506 1 3", wv, wd, wo, wc); else pass_n++;
    idle;
  endtask

  task test_back_to_back;
    set(1, ADD, 3, 4, 0, 1); tick;
    for (int i = 0; i < 5; i++) begin
      set(1, ADD, 50, 50, 0, 0); #1;
      total_n++;
      if ({sr, sv, sd, so, sc} !== {1'b0, 1'b1, 10'd7, 1'b0, 8'd1}) $display("FAIL stall%0d got r=%b v=%b d=%0d o=%b c=%0d want 0 1 7 0 1", i, sr, sv, sd, so, sc); else pass_n++;
      tick;
    end
    set(1, ADD, 50, 50, 0, 1); tick;
    total_n++;
    if ({sv, sd} !== {1'b1, 10'd100}) $display("FAIL release got v=%b d=%0d want 1 100", sv, sd); else pass_n++;
    for (int i = 0; i < 8; i++) begin
      set(1, ADD, i * 10, i, 0, 1); #1;
      total_n++;
      if (sr !== 1'b1) $display("FAIL b2b_ready%0d got %b want 1", i, sr); else pass_n++;
      tick;
      total_n++;
      if ({sv, sd} !== {1'b1, 10'(i * 11)}) $display("FAIL b2b%0d got v=%b d=%0d want 1 %0d", i, sv, sd, i * 11); else pass_n++;
    end
    idle;
  endtask

  task test_abort;
    set(1, ACC, 1, 1, 0, 1); tick;
    rst = 1; set(0, ADD, 0, 0, 0, 1); tick;
    rst = 0;
    set(1, ACC, 2, 2, 1, 1); tick;
    total_n++;
    if ({sv, sd, so, sc} !== {1'b1, 10'd4, 1'b0, 8'd1}) $display("FAIL rst_mid_frame got v=%b d=%0d o=%b c=%0d want 1 4 0 1", sv, sd, so, sc); else pass_n++;
    set(1, ADD, 5, 5, 0, 0); tick;
    rst = 1; set(0, ADD, 0, 0, 0, 0); tick;
    rst = 0; #1;
    total_n++;
    if (sv !== 1'b0) $display("FAIL rst_pending got %b want 0", sv); else pass_n++;
    set(1, ACC, 1, 1, 0, 1); tick;
    set(1, CLR, 9, 9, 0, 1); tick;
    set(1, ACC, 2, 2, 1, 1); tick;
    total_n++;
    if ({sv, sd, so, sc} !== {1'b1, 10'd4, 1'b0, 8'd1}) $display("FAIL clr_mid_frame got v=%b d=%0d o=%b c=%0d want 1 4 0 1", sv, sd, so, sc); else pass_n++;
    idle;
  endtask

  task test_count_saturate;
    for (int i = 0; i < 300; i++) begin
      set(1, ACC, 0, 0, 0, 1); tick;
    end
    set(1, ACC, 0, 1, 1, 1); tick;
    total_n++;
    if ({sv, sd, so, sc} !== {1'b1, 10'd1, 1'b0, 8'd255}) $display("FAIL count_sat got v=%b d=%0d o=%b c=%0d want 1 1 0 255", sv, sd, so, sc); else pass_n++;
    idle;
  endtask

  task test_random;
    int macc[2], mstick[2], md[2], mo[2];
    int mcnt, mc, a, b, r, t, ov;
    logic mv, v, last, ordy, ir, prod;
    logic [1:0] op;
    set(1, CLR, 0, 0, 0, 1); tick;
    mv = 0; mcnt = 0; mc = 0;
    for (int s = 0; s < 2; s++) begin macc[s] = 0; mstick[s] = 0; md[s] = 0; mo[s] = 0; end
    for (int n = 0; n < 400; n++) begin
      v = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 9);
      op = (r < 2) ? ADD : (r < 4) ? SUB : (r < 9) ? ACC : CLR;
      a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      last = $urandom_range(0, 3) == 0;
      ordy = $urandom_range(0, 3) != 0;
      set(v, op, a, b, last, ordy); #1;
      ir = !mv || ordy;
      total_n++;
      if ({sr, wr} !== {ir, ir}) $display("FAIL rnd_ready%0d got %b%b want %b", n, sr, wr, ir); else pass_n++;
      tick;
      prod = 0;
      if (v && ir) begin
        if (op == ADD || op == SUB) begin
          prod = 1; mc = 1;
          for (int s = 0; s < 2; s++) begin
            md[s] = (op == ADD) ? a + b : (a - b + 1024) % 1024;
            mo[s] = (op == SUB) && (a < b);
          end
        end else if (op == ACC) begin
          mcnt = (mcnt < 255) ? mcnt + 1 : 255;
          for (int s = 0; s < 2; s++) begin
            t = macc[s] + a + b;
            ov = t >= 1024;
            if (ov) t = (s == 1) ? 1023 : t - 1024;
            mstick[s] = mstick[s] | ov;
            macc[s] = t;
          end
          if (last) begin
            prod = 1; mc = mcnt;
            for (int s = 0; s < 2; s++) begin md[s] = macc[s]; mo[s] = mstick[s]; macc[s] = 0; mstick[s] = 0; end
            mcnt = 0;
          end
        end else begin
          mcnt = 0;
          for (int s = 0; s < 2; s++) begin macc[s] = 0; mstick[s] = 0; end
        end
      end
      if (prod) mv = 1; else if (ordy) mv = 0;
      total_n++;
      if (sv !== mv || (mv && {sd, so, sc} !== {md[1][9:0], mo[1][0], mc[7:0]}))
        $display("FAIL rnd_sat%0d got v=%b d=%0d o=%b c=%0d want v=%b d=%0d o=%0d c=%0d", n, sv, sd, so, sc, mv, md[1], mo[1], mc);
      else pass_n++;
      total_n++;
      if (wv !== mv || (mv && {wd, wo, wc} !== {md[0][9:0], mo[0][0], mc[7:0]}))
        $display("FAIL rnd_wrap%0d got v=%b d=%0d o=%b c=%0d want v=%b d=%0d o=%0d c=%0d", n, wv, wd, wo, wc, mv, md[0], mo[0], mc);
      else pass_n++;
    end
    idle;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout after %0d checks", total_n);
    $fatal(1);
  end

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_acc;
    test_saturate;
    test_back_to_back;
    test_abort;
    test_count_saturate;
    test_random;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
